mmio_uart_tx: RTL

//  Memory-mapped UART transmitter on the data-side store bus of the MIPS top level.

---
 rtl/mmio_uart_tx_pkg.sv | 27 ++
 rtl/mmio_uart_tx_if.sv | 17 +
 rtl/mmio_uart_tx_fifo.sv | 69 ++++++
 rtl/mmio_uart_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - shared types and constants for the MMIO UART transmitter
// Purpose: FSM state enum, register offsets relative to UART_ADDR, and STATUS bit indices.
// Optional feature macro: UART_PARITY_EN adds the PARITY state between DATA and STOP.
// Ports: none (package).
package mmio_uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } uart_state_e;

  // Register offsets from UART_ADDR.
  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] CTRL_OFS   = 32'd4;

  // STATUS word bit positions.
  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - data-side store bus snooped by the UART transmitter
// Purpose: groups the core's store address, store data and store strobe.
// Signals:
//   dataadr   [31:0]  store byte address (ALU output)
//   writedata [31:0]  store data
//   memwrite          store strobe, sampled at rising clk
// Modports: master (core side drives), slave (UART side listens).
interface mmio_uart_tx_if;

  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        memwrite;

  modport master (output dataadr, output writedata, output memwrite);
  modport slave  (input  dataadr, input  writedata, input  memwrite);

endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// rtl/mmio_uart_tx_fifo.sv - synchronous FIFO used as the UART transmit buffer
// Purpose: DEPTH-entry first-word-fall-through FIFO with registered full/empty flags.
// Ports:
//   clk, reset  clock and synchronous active-high reset (empties the FIFO)
//   push, din   write request and data; accepted when not full or when a pop happens at the same edge
//   pop, dout   read request and head-of-queue data (dout valid whenever empty=0)
//   full, empty registered occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty_q;
  // A pop at the same edge frees the slot, so a full FIFO can still take a push.
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_FULL);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter snooping the core's store bus
// Purpose: stores to UART_ADDR queue a byte; stores to UART_ADDR+4 with bit0 set clear the
// sticky overflow flag. Queued bytes are sent LSB first as 8N1 frames on tx.
// Optional feature macro: UART_PARITY_EN inserts an even parity bit (8E1 frame).
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   bus         store bus (slave modport): dataadr, writedata, memwrite
//   tx          serial output, idles high (registered)
//   busy        1 while a frame is being shifted (registered, state != IDLE)
//   status      {28'b0, overflow, fifo_full, fifo_empty, busy}, all flop outputs
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] UART_ADDR    = 32'h0000_00F0,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx,
  output logic                 busy,
  output logic [31:0]          status
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;

  logic          push_req, ctrl_clr, drop, pop, bit_last;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic          unused_wdata;

  // Exact word-address match; no byte-lane decode.
  assign push_req = bus.memwrite && (bus.dataadr == UART_ADDR + TXDATA_OFS);
  assign ctrl_clr = bus.memwrite && (bus.dataadr == UART_ADDR + CTRL_OFS) && bus.writedata[0];
  assign drop     = push_req && fifo_full && !pop;
  assign unused_wdata = ^bus.writedata[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (bus.writedata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A drop at the same edge as a clear wins, so software never misses an overflow.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)          ovf_d = 1'b1;
    else if (ctrl_clr) ovf_d = 1'b0;
  end

  assign bit_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          par_d   = ^fifo_dout;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_last) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_last) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_last) begin
          cnt_d = '0;
          // Back-to-back frames: load the next byte straight into START.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            par_d   = ^fifo_dout;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // tx and busy are derived from next state so they flip on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = busy_q;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = ovf_q;
  end

endmodule
